// File: rtl/requant_pkg.sv
// Shared types for the requantizer scheduler: side info bundle and FSM states.
// The ZERO state exists only when REQ_ZERO_SKIP_EN is defined.
package requant_pkg;

  localparam int NSAMP = 576;

  typedef struct packed {
    logic                   window_switching_flag;
    logic [1:0]             block_type;
    logic                   mixed_block_flag;
    logic                   scalefac_scale;
    logic [7:0]             global_gain;
    logic                   preflag;
    logic [2:0][2:0]        subblock_gain;
    logic [8:0]             big_values;
    logic [20:0][3:0]       scalefac_l;
    logic [11:0][2:0][3:0]  scalefac_s;
  } side_info_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
`ifdef REQ_ZERO_SKIP_EN
    S_ZERO,
`endif
    S_DONE
  } rqs_state_t;

endpackage

// File: rtl/rqs_delay_line.sv
// Valid/data shift register with async active-low clear.
// pending reports whether any valid will still be in flight after the next edge.
module rqs_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d,
  output logic         pending
);

  logic [DEPTH-1:0]        v_q, v_d;
  logic [DEPTH-1:0][W-1:0] d_q, d_d;

  always_comb begin
    v_d    = v_q;
    d_d    = d_q;
    v_d[0] = in_v;
    d_d[0] = in_d;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    pending = in_v;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | v_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_v = v_q[DEPTH-1];
  assign out_d = d_q[DEPTH-1];

endmodule

// File: rtl/requant_scheduler.sv
// Walks one granule of samples through the requantizer into the output buffer.
// Define REQ_ZERO_SKIP_EN to write positions >= nz_count as zero directly.
module requant_scheduler #(
  parameter int NSAMP   = requant_pkg::NSAMP,
  parameter int SMP_LAT = 2,
  parameter int RQ_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  si_window_switching_flag,
  input  logic [1:0]            si_block_type,
  input  logic                  si_mixed_block_flag,
  input  logic                  si_scalefac_scale,
  input  logic [7:0]            si_global_gain,
  input  logic                  si_preflag,
  input  logic [2:0][2:0]       si_subblock_gain,
  input  logic [8:0]            si_big_values,
  input  logic [20:0][3:0]      si_scalefac_l,
  input  logic [11:0][2:0][3:0] si_scalefac_s,
  input  logic [9:0]            nz_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [9:0]            smp_addr,
  input  logic [15:0]           smp_rdata,
  output logic                  rq_window_switching_flag,
  output logic [1:0]            rq_block_type,
  output logic                  rq_mixed_block_flag,
  output logic                  rq_scalefac_scale,
  output logic [7:0]            rq_global_gain,
  output logic                  rq_preflag,
  output logic [2:0][2:0]       rq_subblock_gain,
  output logic [8:0]            rq_big_values,
  output logic [20:0][3:0]      rq_scalefac_l,
  output logic [11:0][2:0][3:0] rq_scalefac_s,
  output logic [15:0]           rq_x,
  output logic [9:0]            rq_pos,
  output logic                  rq_v,
  input  logic [31:0]           rq_dout,
  input  logic                  rq_dout_v,
  output logic [9:0]            out_addr,
  output logic [31:0]           out_data,
  output logic                  out_we
);

  import requant_pkg::*;

  localparam logic [9:0] NFULL = 10'(NSAMP);
`ifdef REQ_ZERO_SKIP_EN
  localparam logic [9:0] LAST = 10'(NSAMP - 1);
`endif

  rqs_state_t state_q, state_d;
  side_info_t si_q, si_d, si_in;
  logic [9:0] k_q, k_d;
  logic [9:0] n_q, n_d;
  logic [9:0] n_in;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       iss, zw, wr;
  logic       v1, v2, pend1, pend2;
  logic [9:0] p1, p2;

  assign si_in = {si_window_switching_flag, si_block_type,
                  si_mixed_block_flag, si_scalefac_scale,
                  si_global_gain, si_preflag, si_subblock_gain,
                  si_big_values, si_scalefac_l, si_scalefac_s};

`ifdef REQ_ZERO_SKIP_EN
  assign n_in = (nz_count > NFULL) ? NFULL : nz_count;
  assign zw   = (state_q == S_ZERO);
`else
  logic unused_nz;
  assign unused_nz = ^nz_count;
  assign n_in      = NFULL;
  assign zw        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    si_d    = si_q;
    err_d   = err_q | (rq_dout_v & ~v2);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          si_d    = si_in;
          n_d     = n_in;
          k_d     = '0;
          state_d = S_ISSUE;
`ifdef REQ_ZERO_SKIP_EN
          if (n_in == '0) state_d = S_ZERO;
`endif
        end
      end
      S_ISSUE: begin
        if (k_q == n_q - 10'd1) state_d = S_DRAIN;
        else                    k_d     = k_q + 10'd1;
      end
      S_DRAIN: begin
        if (!pend1 && !pend2) begin
`ifdef REQ_ZERO_SKIP_EN
          if (n_q == NFULL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ZERO;
            k_d     = n_q;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef REQ_ZERO_SKIP_EN
      S_ZERO: begin
        if (k_q == LAST) state_d = S_DONE;
        else             k_d     = k_q + 10'd1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      si_q    <= '0;
      k_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      si_q    <= si_d;
      k_q     <= k_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign iss      = (state_q == S_ISSUE);
  assign smp_addr = iss ? k_q : '0;

  rqs_delay_line #(.DEPTH(SMP_LAT), .W(10)) u_smp_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_v    (iss),
    .in_d    (k_q),
    .out_v   (v1),
    .out_d   (p1),
    .pending (pend1)
  );

  rqs_delay_line #(.DEPTH(RQ_LAT), .W(10)) u_rq_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_v    (v1),
    .in_d    (p1),
    .out_v   (v2),
    .out_d   (p2),
    .pending (pend2)
  );

  assign rq_v   = v1;
  assign rq_pos = p1;
  assign rq_x   = v1 ? smp_rdata : '0;

  // an unmatched rq_dout_v is flagged in err and never reaches the buffer
  assign wr       = rq_dout_v & v2;
  assign out_we   = wr | zw;
  assign out_addr = zw ? k_q : p2;
  assign out_data = wr ? rq_dout : '0;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  assign rq_window_switching_flag = si_q.window_switching_flag;
  assign rq_block_type            = si_q.block_type;
  assign rq_mixed_block_flag      = si_q.mixed_block_flag;
  assign rq_scalefac_scale        = si_q.scalefac_scale;
  assign rq_global_gain           = si_q.global_gain;
  assign rq_preflag               = si_q.preflag;
  assign rq_subblock_gain         = si_q.subblock_gain;
  assign rq_big_values            = si_q.big_values;
  assign rq_scalefac_l            = si_q.scalefac_l;
  assign rq_scalefac_s            = si_q.scalefac_s;

endmodule

// File: tb/tb_requant_scheduler.sv
// Directed bench for requant_scheduler with a sample memory and echo requantizer.
// Expectations follow REQ_ZERO_SKIP_EN when it is defined.
module tb_requant_scheduler;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  si_window_switching_flag;
  logic [1:0]            si_block_type;
  logic                  si_mixed_block_flag;
  logic                  si_scalefac_scale;
  logic [7:0]            si_global_gain;
  logic                  si_preflag;
  logic [2:0][2:0]       si_subblock_gain;
  logic [8:0]            si_big_values;
  logic [20:0][3:0]      si_scalefac_l;
  logic [11:0][2:0][3:0] si_scalefac_s;
  logic [9:0]            nz_count;
  logic                  busy, done, err;
  logic [9:0]            smp_addr;
  logic [15:0]           smp_rdata;
  logic                  rq_window_switching_flag;
  logic [1:0]            rq_block_type;
  logic                  rq_mixed_block_flag;
  logic                  rq_scalefac_scale;
  logic [7:0]            rq_global_gain;
  logic                  rq_preflag;
  logic [2:0][2:0]       rq_subblock_gain;
  logic [8:0]            rq_big_values;
  logic [20:0][3:0]      rq_scalefac_l;
  logic [11:0][2:0][3:0] rq_scalefac_s;
  logic [15:0]           rq_x;
  logic [9:0]            rq_pos;
  logic                  rq_v;
  logic [31:0]           rq_dout;
  logic                  rq_dout_v;
  logic [9:0]            out_addr;
  logic [31:0]           out_data;
  logic                  out_we;

  int nchecks = 0;
  int nerrors = 0;

  requant_scheduler dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .si_window_switching_flag (si_window_switching_flag),
    .si_block_type            (si_block_type),
    .si_mixed_block_flag      (si_mixed_block_flag),
    .si_scalefac_scale        (si_scalefac_scale),
    .si_global_gain           (si_global_gain),
    .si_preflag               (si_preflag),
    .si_subblock_gain         (si_subblock_gain),
    .si_big_values            (si_big_values),
    .si_scalefac_l            (si_scalefac_l),
    .si_scalefac_s            (si_scalefac_s),
    .nz_count                 (nz_count),
    .busy                     (busy),
    .done                     (done),
    .err                      (err),
    .smp_addr                 (smp_addr),
    .smp_rdata                (smp_rdata),
    .rq_window_switching_flag (rq_window_switching_flag),
    .rq_block_type            (rq_block_type),
    .rq_mixed_block_flag      (rq_mixed_block_flag),
    .rq_scalefac_scale        (rq_scalefac_scale),
    .rq_global_gain           (rq_global_gain),
    .rq_preflag               (rq_preflag),
    .rq_subblock_gain         (rq_subblock_gain),
    .rq_big_values            (rq_big_values),
    .rq_scalefac_l            (rq_scalefac_l),
    .rq_scalefac_s            (rq_scalefac_s),
    .rq_x                     (rq_x),
    .rq_pos                   (rq_pos),
    .rq_v                     (rq_v),
    .rq_dout                  (rq_dout),
    .rq_dout_v                (rq_dout_v),
    .out_addr                 (out_addr),
    .out_data                 (out_data),
    .out_we                   (out_we)
  );

  always #5 clk = ~clk;

  // sample memory: data = {6'b100000, addr}, two-cycle read latency
  logic [9:0] sm1 = '0, sm2 = '0;
  always @(posedge clk) begin
    sm1 <= smp_addr;
    sm2 <= sm1;
  end
  assign smp_rdata = {6'b100000, sm2};

  // requantizer: two-cycle sign-extending echo, reset with the design
  logic        e1v, e2v, spur;
  logic [15:0] e1d, e2d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1v <= 1'b0; e2v <= 1'b0;
      e1d <= '0;   e2d <= '0;
    end else begin
      e1v <= rq_v; e2v <= e1v;
      e1d <= rq_x; e2d <= e1d;
    end
  end
  assign rq_dout   = {{16{e2d[15]}}, e2d};
  assign rq_dout_v = e2v | spur;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0] nz;
    int         ndata;
    int         done_off;
    bit         extra;
    logic [7:0] gg;
  } vec_t;

  vec_t tbl[5];

  task automatic run_gran(input vec_t v);
    int   c, wc, bad, dc, exp_c;
    bit   seen;
    logic dbusy;
    logic [31:0] expd;
    c = 0; wc = 0; bad = 0; dc = 0; seen = 0; dbusy = 1'b1;
    @(negedge clk);
    start          = 1'b1;
    nz_count       = v.nz;
    si_global_gain = v.gg;
    @(posedge clk);
    while (!seen && c < 700) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start = 1'b0;
        chk("busy_s1", 32'(busy), 32'd1);
        chk("addr_s1", 32'(smp_addr), 32'd0);
      end
      if (v.extra && (c == 10 || c == 581)) start = 1'b1;
      if (v.extra && c == 11) start = 1'b0;
      if (c == 5) si_global_gain = ~v.gg;
      if (c == 100) chk("si_hold", 32'(rq_global_gain), 32'(v.gg));
      if (out_we) begin
        exp_c = (v.ndata == 0 ? 1 : 5) + wc;
        expd  = (wc < v.ndata) ? (32'hFFFF8000 | 32'(wc)) : 32'd0;
        if (out_addr !== 10'(wc) || out_data !== expd || c != exp_c ||
            (wc >= v.ndata && rq_v)) begin
          if (bad == 0)
            $display("first bad write: cyc %0d addr %0d data %0h exp %0h",
                     c, out_addr, out_data, expd);
          bad++;
        end
        wc++;
      end
      if (done) begin
        seen  = 1'b1;
        dc    = c;
        dbusy = busy;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cyc", 32'(dc), 32'(v.done_off));
    chk("done_busy", 32'(dbusy), 32'd0);
    chk("nwrites", 32'(wc), 32'd576);
    chk("badwrites", 32'(bad), 32'd0);
    chk("err_clr", 32'(err), 32'd0);
  endtask

  initial begin
    int wr, dn;
`ifdef REQ_ZERO_SKIP_EN
    tbl[0] = '{10'd576,  576, 581, 1'b1, 8'h3C};
    tbl[1] = '{10'd418,  418, 581, 1'b0, 8'h91};
    tbl[2] = '{10'd0,      0, 577, 1'b0, 8'h05};
    tbl[3] = '{10'd1000, 576, 581, 1'b0, 8'hE7};
    tbl[4] = '{10'd1,      1, 581, 1'b0, 8'h5A};
`else
    tbl[0] = '{10'd576,  576, 581, 1'b1, 8'h3C};
    tbl[1] = '{10'd418,  576, 581, 1'b0, 8'h91};
    tbl[2] = '{10'd0,    576, 581, 1'b0, 8'h05};
    tbl[3] = '{10'd1000, 576, 581, 1'b0, 8'hE7};
    tbl[4] = '{10'd1,    576, 581, 1'b0, 8'h5A};
`endif
    rst_n = 1'b0; start = 1'b0; spur = 1'b0; nz_count = '0;
    si_window_switching_flag = 1'b1; si_block_type = 2'd2;
    si_mixed_block_flag = 1'b0; si_scalefac_scale = 1'b1;
    si_global_gain = 8'h00; si_preflag = 1'b1;
    si_subblock_gain = 9'h1A5; si_big_values = 9'd288;
    si_scalefac_l = {21{4'hA}}; si_scalefac_s = {36{4'h5}};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(out_we), 32'd0);
    chk("rst_rqv", 32'(rq_v), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_gran(tbl[i]);
    chk("sbg_latched", 32'(rq_subblock_gain), 32'h1A5);

    // abort a granule with reset mid-flight
    @(negedge clk);
    start = 1'b1; nz_count = 10'd576;
    @(posedge clk);
    repeat (200) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rqv", 32'(rq_v), 32'd0);
    chk("abort_we", 32'(out_we), 32'd0);
    chk("abort_saddr", 32'(smp_addr), 32'd0);
    chk("abort_oaddr", 32'(out_addr), 32'd0);
    chk("abort_odata", out_data, 32'd0);
    chk("abort_rqpos", 32'(rq_pos), 32'd0);
    chk("abort_rqx", 32'(rq_x), 32'd0);
    chk("abort_gg", 32'(rq_global_gain), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr = 0; dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_we) wr++;
      if (done) dn++;
    end
    chk("abort_nowrite", 32'(wr), 32'd0);
    chk("abort_nodone", 32'(dn), 32'd0);
    run_gran(tbl[0]);

    // unmatched requantizer output while idle
    @(negedge clk);
    spur = 1'b1;
    #1;
    chk("spur_we", 32'(out_we), 32'd0);
    @(negedge clk);
    spur = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    repeat (10) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("err_rst", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
